// File: rtl/counter_down_sync_pkg.sv
// Shared constants and control encoding for the synchronous down counter.
// The RTL and the bench both use these names for the load > enable > hold priority.
package counter_down_sync_pkg;

  localparam int unsigned COUNT_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    CTRL_HOLD = 2'd0,
    CTRL_DEC  = 2'd1,
    CTRL_LOAD = 2'd2
  } ctrl_e;

  // All-ones value for a counter of the given width (2..16 bits).
  function automatic logic [15:0] all_ones(input int unsigned width);
    return 16'((32'd1 << width) - 32'd1);
  endfunction

  function automatic ctrl_e ctrl_decode(input logic load, input logic enable);
    if (load)        return CTRL_LOAD;
    else if (enable) return CTRL_DEC;
    else             return CTRL_HOLD;
  endfunction

endpackage

// File: rtl/counter_down_stage.sv
// One bit slice of the down counter: T flop with async clear and a load mux in front.
// toggle_out propagates the borrow chain: the next bit toggles only while this bit is zero.
module counter_down_stage (
  input  logic clock,
  input  logic clear,
  input  logic toggle_in,
  input  logic load,
  input  logic load_bit,
  output logic q,
  output logic toggle_out
);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q <= 1'b0;
    end else if (load) begin
      q <= load_bit;
    end else if (toggle_in) begin
      q <= ~q;
    end
  end

  assign toggle_out = toggle_in & ~q;

endmodule

// File: rtl/counter_down_sync.sv
// Loadable synchronous binary down counter with zero decode and registered borrow pulse.
// WIDTH stages share one clock; the toggle chain replaces a ripple-clocked structure.
module counter_down_sync
  import counter_down_sync_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state,
  output logic             zero,
  output logic             borrow
);

  logic [WIDTH:0] toggle;
  ctrl_e          ctrl;
  logic           borrow_next;

  assign toggle[0] = enable;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    counter_down_stage u_stage (
      .clock      (clock),
      .clear      (clear),
      .toggle_in  (toggle[i]),
      .load       (load),
      .load_bit   (load_value[i]),
      .q          (state[i]),
      .toggle_out (toggle[i+1])
    );
  end

  always_comb begin
    ctrl = ctrl_decode(load, enable);
  end

  // The chain carries out of the top bit only when enabled with every bit zero: the wrap edge.
  always_comb begin
    borrow_next = 1'b0;
    if (ctrl == CTRL_DEC) begin
      borrow_next = toggle[WIDTH];
    end
  end

  assign zero = (state == '0);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      borrow <= 1'b0;
    end else begin
      borrow <= borrow_next;
    end
  end

endmodule

// File: tb/tb_counter_down_sync.sv
// Self-checking bench for counter_down_sync (WIDTH = 4) using an expected-result queue.
module tb_counter_down_sync;
  import counter_down_sync_pkg::*;

  localparam int unsigned WIDTH = 4;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] state;
    logic             borrow;
  } exp_t;

  logic             clock = 1'b0;
  logic             clear = 1'b1;
  logic             enable = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic [WIDTH-1:0] state;
  logic             zero;
  logic             borrow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_state  = '0;
  logic             m_borrow = 1'b0;

  counter_down_sync #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .clear      (clear),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .state      (state),
    .zero       (zero),
    .borrow     (borrow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [WIDTH-1:0] exp_state,
                               input logic exp_borrow);
    check_val({tag, ".state"},  32'(state),  32'(exp_state));
    check_val({tag, ".zero"},   32'(zero),   32'(exp_state == '0));
    check_val({tag, ".borrow"}, 32'(borrow), 32'(exp_borrow));
  endtask

  // Drive one cycle of controls, predict the post-edge result, then compare after the edge.
  task automatic step(input string tag, input logic ld, input logic en,
                      input logic [WIDTH-1:0] lv);
    exp_t e;
    load       = ld;
    enable     = en;
    load_value = lv;
    if (ld) begin
      m_state  = lv;
      m_borrow = 1'b0;
    end else if (en) begin
      m_borrow = (m_state == '0);
      m_state  = (m_state == '0) ? WIDTH'(all_ones(WIDTH)) : m_state - 1'b1;
    end else begin
      m_borrow = 1'b0;
    end
    e.tag    = tag;
    e.state  = m_state;
    e.borrow = m_borrow;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check_val({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_outputs(e.tag, e.state, e.borrow);
    end
  endtask

  task automatic async_clear(input string tag);
    clear = 1'b1;
    #1;
    m_state  = '0;
    m_borrow = 1'b0;
    check_outputs(tag, m_state, m_borrow);
  endtask

  initial begin
    // 1. Reset held across edges with load and enable active
    enable = 1'b1;
    load = 1'b1;
    load_value = 4'hA;
    #1;
    check_outputs("rst0", 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_outputs("rst_hold", 4'h0, 1'b0);
    end
    clear = 1'b0;

    // 2. Load then count through the wrap
    step("load3", 1'b1, 1'b0, 4'h3);
    for (int i = 0; i < 4; i++) step("cnt", 1'b0, 1'b1, 4'h0);
    step("after_wrap", 1'b0, 1'b1, 4'h0);

    // Async clear between edges from a nonzero state
    @(negedge clock);
    async_clear("async_mid");
    #1 clear = 1'b0;

    // 3. Hold and priority
    step("load5", 1'b1, 1'b0, 4'h5);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 4'h0);
    step("load_prio", 1'b1, 1'b1, 4'h9);

    // 4. Full wrap from F
    step("loadF", 1'b1, 1'b0, 4'hF);
    for (int i = 0; i < 16; i++) step("wrap16", 1'b0, 1'b1, 4'h0);
    step("post16", 1'b0, 1'b0, 4'h0);

    // 5. Reset mid-borrow
    step("load0", 1'b1, 1'b0, 4'h0);
    step("borrow_on", 1'b0, 1'b1, 4'h0);
    @(negedge clock);
    async_clear("clr_borrow");
    #2 clear = 1'b0;
    step("rel_wrap", 1'b0, 1'b1, 4'h0);

    // 6. Load zero while counting, then wrap; also back-to-back wraps via load 0
    step("load2", 1'b1, 1'b0, 4'h2);
    step("ldzero", 1'b1, 1'b1, 4'h0);
    step("wrap_ld0", 1'b0, 1'b1, 4'h0);
    step("ldzero2", 1'b1, 1'b0, 4'h0);
    step("wrap_b2b", 1'b0, 1'b1, 4'h0);

    // Random mix of controls
    for (int i = 0; i < 60; i++) begin
      step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)));
    end

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
